matrix_coef_loader: RTL and testbench

MATRIX_COEF_LOADER -- requirements
Module: matrix_coef_loader

---
 rtl/matrix_coef_loader.sv | 148 ++++++++++++++
 tb/tb_matrix_coef_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_coef_loader.sv
// Coefficient loader for a 3x3 sign-magnitude matrix: words fill a shadow bank and are swapped into the active bank on frame_sync.
// Optional trailing XOR checksum word is enabled by defining COEF_CHECKSUM_EN.
module matrix_coef_loader #(
  parameter int MSIZE = 9,
  parameter int UNITY = 128
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic [MSIZE-1:0] coef_in,
  input  logic             coef_valid,
  output logic             coef_ready,
  input  logic             frame_sync,
  output logic [MSIZE-1:0] M00,
  output logic [MSIZE-1:0] M01,
  output logic [MSIZE-1:0] M02,
  output logic [MSIZE-1:0] M10,
  output logic [MSIZE-1:0] M11,
  output logic [MSIZE-1:0] M12,
  output logic [MSIZE-1:0] M20,
  output logic [MSIZE-1:0] M21,
  output logic [MSIZE-1:0] M22,
  output logic             upd_done,
  output logic             busy,
  output logic             err
);

`ifdef COEF_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHK, PEND} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;
`endif

  localparam logic [MSIZE-1:0] UNITY_W = MSIZE'(UNITY);
  localparam logic [MSIZE-1:0] NEG_ZERO = {1'b1, {(MSIZE-1){1'b0}}};

  state_t           state_q, state_d;
  logic [3:0]       idx_q;
  logic [MSIZE-1:0] shadow_q [9];
  logic [MSIZE-1:0] active_q [9];
  logic             upd_q;
  logic             accept;
  logic             lastWord;
  logic [MSIZE-1:0] normWord;

  assign accept   = coef_valid && coef_ready;
  assign lastWord = (idx_q == 4'd8);
  assign normWord = (coef_in == NEG_ZERO) ? '0 : coef_in;

`ifdef COEF_CHECKSUM_EN
  logic [MSIZE-1:0] csum_q;
  logic             err_q;
  logic             csumOk;
  assign csumOk = (coef_in == csum_q);
  assign err    = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // load_start restarts from any state and beats a word accepted in the same cycle
  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = LOAD;
    end else begin
      case (state_q)
`ifdef COEF_CHECKSUM_EN
        LOAD:    if (accept && lastWord) state_d = CHK;
        CHK:     if (accept) state_d = csumOk ? PEND : IDLE;
`else
        LOAD:    if (accept && lastWord) state_d = PEND;
`endif
        PEND:    if (frame_sync) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    coef_ready = 1'b0;
    busy       = 1'b0;
    case (state_q)
      LOAD: begin coef_ready = 1'b1; busy = 1'b1; end
`ifdef COEF_CHECKSUM_EN
      CHK:  begin coef_ready = 1'b1; busy = 1'b1; end
`endif
      PEND: busy = 1'b1;
      default: ;
    endcase
  end

  // Both banks come out of reset as the identity so a dropped load can never swap in garbage
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      upd_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        shadow_q[i] <= (i == 0 || i == 4 || i == 8) ? UNITY_W : '0;
        active_q[i] <= (i == 0 || i == 4 || i == 8) ? UNITY_W : '0;
      end
`ifdef COEF_CHECKSUM_EN
      csum_q <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      upd_q <= 1'b0;
      if (load_start) begin
        idx_q <= '0;
`ifdef COEF_CHECKSUM_EN
        csum_q <= '0;
        err_q  <= 1'b0;
`endif
      end else begin
        if (state_q == LOAD && accept) begin
          shadow_q[idx_q] <= normWord;
          idx_q           <= lastWord ? 4'd0 : idx_q + 4'd1;
`ifdef COEF_CHECKSUM_EN
          csum_q <= csum_q ^ coef_in;
`endif
        end
`ifdef COEF_CHECKSUM_EN
        if (state_q == CHK && accept && !csumOk) err_q <= 1'b1;
`endif
        if (state_q == PEND && frame_sync) begin
          active_q <= shadow_q;
          upd_q    <= 1'b1;
        end
      end
    end
  end

  assign upd_done = upd_q;
  assign M00 = active_q[0];
  assign M01 = active_q[1];
  assign M02 = active_q[2];
  assign M10 = active_q[3];
  assign M11 = active_q[4];
  assign M12 = active_q[5];
  assign M20 = active_q[6];
  assign M21 = active_q[7];
  assign M22 = active_q[8];

endmodule

// File: tb/tb_matrix_coef_loader.sv
// Scoreboard bench for matrix_coef_loader: stimulus queues expected matrices, a negedge monitor checks every swap and that M never moves otherwise.
// Define COEF_CHECKSUM_EN for both files to exercise the checksum word.
module tb_matrix_coef_loader;
  localparam int MSIZE = 9;
  localparam int UNITY = 128;

  logic clock = 1'b0;
  logic rst_n, load_start, coef_valid, coef_ready, frame_sync;
  logic [MSIZE-1:0] coef_in;
  logic [MSIZE-1:0] M00, M01, M02, M10, M11, M12, M20, M21, M22;
  logic upd_done, busy, err;

  int checks = 0;
  int failures = 0;

  logic [80:0] expQ [$];
  logic [80:0] modelActive;
  logic        pendingValid;
  logic [80:0] pendingMatrix;
  logic [8:0]  loadWords [9];

  always #5 clock = ~clock;

  matrix_coef_loader #(.MSIZE(MSIZE), .UNITY(UNITY)) dut (
    .clock(clock), .rst_n(rst_n), .load_start(load_start), .coef_in(coef_in),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .frame_sync(frame_sync),
    .M00(M00), .M01(M01), .M02(M02), .M10(M10), .M11(M11), .M12(M12),
    .M20(M20), .M21(M21), .M22(M22),
    .upd_done(upd_done), .busy(busy), .err(err)
  );

  function automatic logic [80:0] identityMatrix();
    logic [80:0] m = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m[80 - 9*(3*r + c) -: 9] = (r == c) ? 9'(UNITY) : 9'd0;
    return m;
  endfunction

  // Negative zero is the only word that changes on its way into the matrix
  function automatic logic [80:0] matrixOfLoad();
    logic [80:0] m = '0;
    for (int i = 0; i < 9; i++)
      m[80 - 9*i -: 9] = (loadWords[i] == 9'h100) ? 9'd0 : loadWords[i];
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ls, input logic v, input logic [8:0] w, input logic fs);
    load_start = ls; coef_valid = v; coef_in = w; frame_sync = fs;
    @(posedge clock); #1;
    load_start = 1'b0; coef_valid = 1'b0; frame_sync = 1'b0;
  endtask

  function automatic logic [8:0] randWord();
    return ($urandom_range(0, 7) == 0) ? 9'h100 : 9'($urandom_range(0, 511));
  endfunction

  // Monitor: swaps must match the queue head; between swaps M must stay put
  initial begin
    modelActive = identityMatrix();
    forever begin
      @(negedge clock);
      if (!rst_n) begin
        modelActive = identityMatrix();
        checkOutput("updDuringReset", upd_done, 0);
      end else if (upd_done) begin
        checkOutput("updExpected", expQ.size() != 0, 1);
        if (expQ.size() != 0) modelActive = expQ.pop_front();
      end
      checkOutput("activeMatrix", {M00, M01, M02, M10, M11, M12, M20, M21, M22}, modelActive);
    end
  end

  task automatic sendLoad(input bit allowGaps, input bit fsOnLast, input bit badCsum);
    logic [8:0] csum = '0;
    pendingValid = 1'b0;
    applyStimulus(1'b1, 1'($urandom_range(0, 1)), randWord(), 1'b0);
    checkOutput("readyInLoad", {busy, coef_ready}, 2'b11);
    for (int i = 0; i < 9; i++) begin
      while (allowGaps && $urandom_range(0, 3) == 0)
        applyStimulus(1'b0, 1'b0, randWord(), 1'($urandom_range(0, 1)));
      csum ^= loadWords[i];
`ifdef COEF_CHECKSUM_EN
      applyStimulus(1'b0, 1'b1, loadWords[i], 1'b0);
`else
      applyStimulus(1'b0, 1'b1, loadWords[i], (i == 8) && fsOnLast);
`endif
    end
`ifdef COEF_CHECKSUM_EN
    applyStimulus(1'b0, 1'b1, csum ^ {8'd0, badCsum}, fsOnLast);
`endif
    if (!badCsum) begin
      pendingValid  = 1'b1;
      pendingMatrix = matrixOfLoad();
      checkOutput("pendBusy", {busy, coef_ready}, 2'b10);
    end
  endtask

  task automatic partialLoad(input int n);
    pendingValid = 1'b0;
    applyStimulus(1'b1, 1'b0, 9'd0, 1'b0);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, randWord(), 1'b0);
  endtask

  task automatic frameSync();
    if (pendingValid) begin
      expQ.push_back(pendingMatrix);
      pendingValid = 1'b0;
    end
    applyStimulus(1'b0, 1'b0, 9'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 9'd0, 1'b0);
    checkOutput("swapConsumed", expQ.size(), 0);
    checkOutput("idleAfterSync", busy, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; load_start = 1'b0; coef_valid = 1'b0; coef_in = '0; frame_sync = 1'b0;
    pendingValid = 1'b0; pendingMatrix = '0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("resetOutputs", {busy, coef_ready, upd_done, err}, 4'b0000);
    rst_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 9'd0, 1'b0);
    checkOutput("idleAfterReset", {busy, coef_ready}, 2'b00);

    // Words 1..9 back to back, swap five cycles later
    for (int i = 0; i < 9; i++) loadWords[i] = 9'(i + 1);
    sendLoad(1'b0, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 9'd0, 1'b0);
    frameSync();

    // Aborted partial load followed by an all-0x1FF load
    partialLoad(4);
    for (int i = 0; i < 9; i++) loadWords[i] = 9'h1FF;
    sendLoad(1'b0, 1'b0, 1'b0);
    frameSync();

    // Negative zero in M12 becomes zero
    for (int i = 0; i < 9; i++) loadWords[i] = 9'($urandom_range(1, 255));
    loadWords[5] = 9'h100;
    sendLoad(1'b1, 1'b0, 1'b0);
    frameSync();

    // frame_sync coinciding with the final word does not swap; the next one does
    for (int i = 0; i < 9; i++) loadWords[i] = randWord();
    sendLoad(1'b0, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 9'd0, 1'b0);
    frameSync();

    // frame_sync in IDLE has no effect
    frameSync();

    // Reset after six words: identity restored and no swap afterwards
    partialLoad(6);
    rst_n = 1'b0;
    expQ.delete();
    pendingValid = 1'b0;
    applyStimulus(1'b0, 1'b0, 9'd0, 1'b0);
    checkOutput("resetMidLoad", {busy, coef_ready, err}, 3'b000);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 9'd0, 1'b0);
    frameSync();

`ifdef COEF_CHECKSUM_EN
    for (int i = 0; i < 9; i++) loadWords[i] = randWord();
    sendLoad(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 9'd0, 1'b0);
    checkOutput("csumErr", {err, busy}, 2'b10);
    frameSync();
    partialLoad(0);
    checkOutput("errCleared", err, 0);
`else
    checkOutput("errTiedLow", err, 0);
`endif

    // Random loads with gaps, ignored frame_sync noise, aborts and superseded pending loads
    for (int iter = 0; iter < 12; iter++) begin
      if ($urandom_range(0, 3) == 0) partialLoad($urandom_range(1, 8));
      for (int i = 0; i < 9; i++) loadWords[i] = randWord();
      sendLoad(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 1'b0, 9'd0, 1'b0);
      if ($urandom_range(0, 4) != 0) frameSync();
    end
    frameSync();

    checkOutput("queueDrained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
